debug_cmd_parser: RTL

DEBUG_CMD_PARSER -- requirements
Module: debug_cmd_parser

---
 rtl/debug_cmd_parser.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/debug_cmd_parser.sv
// UART debug command parser: sets count/address, reads or writes memory words, alive and core reset.
// Define DEBUG_CMD_ACK_EN to send an XOR acknowledge byte after SET_COUNT, SET_ADDR and each write.
module debug_cmd_parser (
    input  logic        clk,
    input  logic        asyncrst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        mem_wen,
    output logic        mem_ren,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        core_rst_hold,
    output logic        rx_overrun
);

`ifdef DEBUG_CMD_ACK_EN
    localparam bit AckEn = 1'b1;
`else
    localparam bit AckEn = 1'b0;
`endif

    localparam logic [7:0] CmdSetCount = 8'h82;
    localparam logic [7:0] CmdSetAddr  = 8'h83;
    localparam logic [7:0] CmdRead     = 8'h84;
    localparam logic [7:0] CmdWrite    = 8'h85;
    localparam logic [7:0] CmdAlive    = 8'h86;
    localparam logic [7:0] CmdCoreRst  = 8'h87;
    localparam logic [7:0] CmdCoreNorm = 8'h88;

    typedef enum logic [3:0] {
        StIdle,
        StGetCount,
        StGetAddr,
        StGetWdata,
        StMemWr,
        StMemRd,
        StSendRdata,
        StSendAlive,
        StSendAck
    } state_e;

    state_e      state_q, state_d;
    state_e      ack_ret_q, ack_ret_d;
    logic [7:0]  count_q, count_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [23:0] rdata_q, rdata_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        mem_wen_q, mem_wen_d;
    logic        mem_ren_q, mem_ren_d;
    logic        hold_q, hold_d;
    logic        overrun_q, overrun_d;

    logic [31:0] word;
    logic        tx_done;
    state_e      wr_next;

    function automatic logic [7:0] xor_bytes(input logic [31:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

    assign word    = {shift_q, rx_data};
    assign tx_done = tx_valid_q & tx_ready;
    assign wr_next = (count_q != 8'd1) ? StGetWdata : StIdle;

    always_comb begin
        state_d    = state_q;
        ack_ret_d  = ack_ret_q;
        count_d    = count_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        mem_wen_d  = mem_wen_q;
        mem_ren_d  = mem_ren_q;
        hold_d     = hold_q;
        overrun_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    byte_cnt_d = 2'd0;
                    case (rx_data)
                        CmdSetCount: state_d = StGetCount;
                        CmdSetAddr:  state_d = StGetAddr;
                        CmdRead: begin
                            if (count_q != 8'd0) begin
                                state_d   = StMemRd;
                                mem_ren_d = 1'b1;
                            end
                        end
                        CmdWrite: begin
                            if (count_q != 8'd0) state_d = StGetWdata;
                        end
                        CmdAlive: begin
                            state_d    = StSendAlive;
                            tx_valid_d = 1'b1;
                            tx_data_d  = 8'h00;
                        end
                        CmdCoreRst:  hold_d = 1'b1;
                        CmdCoreNorm: hold_d = 1'b0;
                        default: ;
                    endcase
                end
            end
            StGetCount: begin
                if (rx_valid) begin
                    count_d = rx_data;
                    if (AckEn) begin
                        state_d    = StSendAck;
                        ack_ret_d  = StIdle;
                        tx_valid_d = 1'b1;
                        tx_data_d  = rx_data;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StGetAddr: begin
                if (rx_valid) begin
                    shift_d    = word[23:0];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        addr_d = word;
                        if (AckEn) begin
                            state_d    = StSendAck;
                            ack_ret_d  = StIdle;
                            tx_valid_d = 1'b1;
                            tx_data_d  = xor_bytes(word);
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            StGetWdata: begin
                if (rx_valid) begin
                    shift_d    = word[23:0];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wdata_d   = word;
                        mem_wen_d = 1'b1;
                        state_d   = StMemWr;
                    end
                end
            end
            StMemWr: begin
                overrun_d = rx_valid;
                if (mem_ready) begin
                    mem_wen_d = 1'b0;
                    addr_d    = addr_q + 32'd4;
                    count_d   = count_q - 8'd1;
                    if (AckEn) begin
                        state_d    = StSendAck;
                        ack_ret_d  = wr_next;
                        tx_valid_d = 1'b1;
                        tx_data_d  = xor_bytes(wdata_q);
                    end else begin
                        state_d = wr_next;
                    end
                end
            end
            StMemRd: begin
                overrun_d = rx_valid;
                if (mem_ready) begin
                    mem_ren_d  = 1'b0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = mem_rdata[31:24];
                    rdata_d    = mem_rdata[23:0];
                    byte_cnt_d = 2'd0;
                    state_d    = StSendRdata;
                end
            end
            StSendRdata: begin
                overrun_d = rx_valid;
                if (tx_done) begin
                    if (byte_cnt_q == 2'd3) begin
                        tx_valid_d = 1'b0;
                        byte_cnt_d = 2'd0;
                        addr_d     = addr_q + 32'd4;
                        count_d    = count_q - 8'd1;
                        if (count_q != 8'd1) begin
                            state_d   = StMemRd;
                            mem_ren_d = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        tx_data_d  = rdata_q[23:16];
                        rdata_d    = {rdata_q[15:0], 8'h00};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            StSendAlive: begin
                overrun_d = rx_valid;
                if (tx_done) begin
                    if (byte_cnt_q == 2'd0) begin
                        tx_data_d  = 8'hAE;
                        byte_cnt_d = 2'd1;
                    end else begin
                        tx_valid_d = 1'b0;
                        byte_cnt_d = 2'd0;
                        state_d    = StIdle;
                    end
                end
            end
            StSendAck: begin
                overrun_d = rx_valid;
                if (tx_done) begin
                    tx_valid_d = 1'b0;
                    state_d    = ack_ret_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge asyncrst) begin
        if (asyncrst) begin
            state_q    <= StIdle;
            ack_ret_q  <= StIdle;
            count_q    <= 8'd1;
            byte_cnt_q <= 2'd0;
            shift_q    <= '0;
            rdata_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            mem_wen_q  <= 1'b0;
            mem_ren_q  <= 1'b0;
            hold_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_ret_q  <= ack_ret_d;
            count_q    <= count_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            mem_wen_q  <= mem_wen_d;
            mem_ren_q  <= mem_ren_d;
            hold_q     <= hold_d;
            overrun_q  <= overrun_d;
        end
    end

    assign tx_valid      = tx_valid_q;
    assign tx_data       = tx_data_q;
    assign mem_wen       = mem_wen_q;
    assign mem_ren       = mem_ren_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign core_rst_hold = hold_q;
    assign rx_overrun    = overrun_q;

endmodule
